// File: rtl/ama_pipe_adder.sv
// Pipelined approximate adder of 4-bit mirror-adder segments (exact or AMA4).
// Define AMA_ERR_MON_EN to add the exact shadow adder and error monitor.
module ama_pipe_adder #(
  parameter  int WIDTH         = 32,
  parameter  int SEG_PER_STAGE = 2,
  localparam int NSEG          = WIDTH / 4,
  localparam int STAGES        = NSEG / SEG_PER_STAGE,
  localparam int APW           = $clog2(NSEG + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [APW-1:0]   appr_segs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef AMA_ERR_MON_EN
  ,
  input  logic             err_clr,
  output logic             err_flag,
  output logic [15:0]      err_cnt
`endif
);

  function automatic logic [4:0] seg_add(
    input logic [3:0] x,
    input logic [3:0] y,
    input logic       ci,
    input logic       ap
  );
    logic [3:0] s;
    logic       c;
    c = ci;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      if (ap) begin
        s[i] = y[i] & (~x[i] | c);
        c    = x[i];
      end else begin
        s[i] = x[i] ^ y[i] ^ c;
        c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
      end
    end
    return {c, s};
  endfunction

  logic [STAGES-1:0] r_v;
  logic [WIDTH-1:0]  r_a    [STAGES];
  logic [WIDTH-1:0]  r_b    [STAGES];
  logic [WIDTH-1:0]  r_sum  [STAGES];
  logic              r_c    [STAGES];
  logic [APW-1:0]    r_appr [STAGES];

  logic [STAGES-1:0] w_v_src;
  logic [WIDTH-1:0]  w_a_src    [STAGES];
  logic [WIDTH-1:0]  w_b_src    [STAGES];
  logic [WIDTH-1:0]  w_sum_src  [STAGES];
  logic              w_c_src    [STAGES];
  logic [APW-1:0]    w_appr_src [STAGES];
  logic [WIDTH-1:0]  w_sum_nx   [STAGES];
  logic              w_c_nx     [STAGES];
  logic [STAGES-1:0] w_load;
  logic [APW-1:0]    w_appr_sat;

  assign w_appr_sat = (appr_segs > APW'(NSEG)) ? APW'(NSEG) : appr_segs;

  always_comb begin
    w_v_src[0]    = in_valid;
    w_a_src[0]    = a;
    w_b_src[0]    = b;
    w_sum_src[0]  = '0;
    w_c_src[0]    = cin;
    w_appr_src[0] = w_appr_sat;
    for (int k = 1; k < STAGES; k++) begin
      w_v_src[k]    = r_v[k-1];
      w_a_src[k]    = r_a[k-1];
      w_b_src[k]    = r_b[k-1];
      w_sum_src[k]  = r_sum[k-1];
      w_c_src[k]    = r_c[k-1];
      w_appr_src[k] = r_appr[k-1];
    end
  end

  // A stage may load unless it and every stage after it are full
  // while the consumer stalls.
  always_comb begin
    logic full;
    full   = 1'b1;
    w_load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full      = full & r_v[k];
      w_load[k] = out_ready | ~full;
    end
  end

  always_comb begin
    logic       c;
    logic [4:0] t;
    c = 1'b0;
    t = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_sum_nx[k] = w_sum_src[k];
      c           = w_c_src[k];
      for (int s = 0; s < SEG_PER_STAGE; s++) begin
        t = seg_add(
          w_a_src[k][4*(k*SEG_PER_STAGE+s) +: 4],
          w_b_src[k][4*(k*SEG_PER_STAGE+s) +: 4],
          c,
          (k * SEG_PER_STAGE + s) < int'(w_appr_src[k])
        );
        w_sum_nx[k][4*(k*SEG_PER_STAGE+s) +: 4] = t[3:0];
        c = t[4];
      end
      w_c_nx[k] = c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]    <= '0;
        r_b[k]    <= '0;
        r_sum[k]  <= '0;
        r_c[k]    <= 1'b0;
        r_appr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_v[k]    <= w_v_src[k];
          r_a[k]    <= w_a_src[k];
          r_b[k]    <= w_b_src[k];
          r_sum[k]  <= w_sum_nx[k];
          r_c[k]    <= w_c_nx[k];
          r_appr[k] <= w_appr_src[k];
        end
      end
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_v[STAGES-1];
  assign sum       = r_sum[STAGES-1];
  assign cout      = r_c[STAGES-1];

`ifdef AMA_ERR_MON_EN
  logic [WIDTH:0] r_x [STAGES];
  logic [WIDTH:0] w_x_src [STAGES];
  logic [15:0]    r_err_cnt;

  always_comb begin
    w_x_src[0] = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    for (int k = 1; k < STAGES; k++) begin
      w_x_src[k] = r_x[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_x[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_x[k] <= w_x_src[k];
        end
      end
    end
  end

  assign err_flag = r_v[STAGES-1] &
    ({r_c[STAGES-1], r_sum[STAGES-1]} != r_x[STAGES-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= '0;
    end else if (out_valid & out_ready & err_flag & ~&r_err_cnt) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_ama_pipe_adder.sv
// Scoreboard bench for ama_pipe_adder: random and directed beats,
// backpressure, appr_segs saturation and mid-stream reset.
module tb_ama_pipe_adder;
  localparam int WIDTH  = 32;
  localparam int SPS    = 2;
  localparam int NSEG   = WIDTH / 4;
  localparam int STAGES = NSEG / SPS;
  localparam int APW    = $clog2(NSEG + 1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [APW-1:0]   appr_segs;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef AMA_ERR_MON_EN
  logic             err_clr;
  logic             err_flag;
  logic [15:0]      err_cnt;
`endif

  ama_pipe_adder #(.WIDTH(WIDTH), .SEG_PER_STAGE(SPS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .cin(cin),
    .appr_segs(appr_segs),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .cout(cout)
`ifdef AMA_ERR_MON_EN
    ,
    .err_clr(err_clr),
    .err_flag(err_flag),
    .err_cnt(err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             e;
    int               acc;
    int               st;
  } exp_t;

  exp_t        q[$];
  int          checks;
  int          fails;
  int          cyc;
  int          stall_cnt;
  logic [15:0] ref_cnt;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Bit-serial reading of the cell rules: low min(appr,NSEG) nibbles
  // use AMA4 cells, the rest are full adders.
  function automatic logic [WIDTH:0] ref_add(
    input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
    input logic ci, input logic [APW-1:0] ap);
    int               na;
    logic             c;
    logic [WIDTH-1:0] s;
    na = (int'(ap) > NSEG) ? NSEG : int'(ap);
    c  = ci;
    s  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if ((i / 4) < na) begin
        s[i] = y[i] & (~x[i] | c);
        c    = x[i];
      end else begin
        s[i] = x[i] ^ y[i] ^ c;
        c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
      end
    end
    return {c, s};
  endfunction

  function automatic void push(
    input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
    input logic ci, input logic [APW-1:0] ap,
    input bit use_k, input logic [WIDTH:0] kr, input logic ke);
    exp_t           e;
    logic [WIDTH:0] r;
    logic [WIDTH:0] ex;
    ex    = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    r     = use_k ? kr : ref_add(x, y, ci, ap);
    e.s   = r[WIDTH-1:0];
    e.c   = r[WIDTH];
    e.e   = use_k ? ke : (r != ex);
    e.acc = cyc;
    e.st  = stall_cnt;
    q.push_back(e);
  endfunction

  // Monitor: samples 2 ns before each rising edge.
  initial begin
    exp_t             e;
    logic             hold;
    logic [WIDTH-1:0] ps;
    logic             pc;
    hold = 1'b0;
    ps   = '0;
    pc   = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        hold = 1'b0;
        continue;
      end
      cyc++;
      check("in_ready", in_ready, (q.size() < STAGES) || out_ready);
      if (hold) begin
        check("stall_valid", out_valid, 1);
        check("stall_sum", sum, ps);
        check("stall_cout", cout, pc);
      end
`ifdef AMA_ERR_MON_EN
      check("err_cnt", err_cnt, ref_cnt);
`endif
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_out got=%0h exp=none", sum);
        end else begin
          e = q.pop_front();
          check("sum", sum, e.s);
          check("cout", cout, e.c);
          if (e.st == stall_cnt) check("latency", cyc - e.acc, STAGES);
`ifdef AMA_ERR_MON_EN
          check("err_flag", err_flag, e.e);
          if (e.e && ref_cnt != 16'hFFFF) ref_cnt = ref_cnt + 16'd1;
`endif
        end
      end
`ifdef AMA_ERR_MON_EN
      if (err_clr) ref_cnt = '0;
`endif
      if (!out_ready) stall_cnt++;
      hold = out_valid && !out_ready;
      ps   = sum;
      pc   = cout;
    end
  end

  task automatic put(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                     input logic ci, input logic [APW-1:0] ap,
                     input bit use_k, input logic [WIDTH:0] kr,
                     input logic ke, output int tries);
    tries = 0;
    @(negedge clk);
    a         = x;
    b         = y;
    cin       = ci;
    appr_segs = ap;
    in_valid  = 1'b1;
    forever begin
      #4;
      tries++;
      if (in_ready) begin
        push(x, y, ci, ap, use_k, kr, ke);
        break;
      end
      if (tries >= 200) begin
        checks++;
        fails++;
        $display("FAIL accept_timeout got=%0d exp=<200", tries);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout got=%0d exp=0", q.size());
    end
  endtask

  task automatic stream(input int n, input bit dense, input int lo,
                        input int hi, input bit rnd, output int low);
    int   idx;
    int   c;
    bit   pend;
    low  = 0;
    idx  = 0;
    c    = 0;
    pend = 0;
    while (idx < n && c < 5000) begin
      @(negedge clk);
      if (rnd) out_ready = ($urandom % 4) != 0;
      else out_ready = !(c >= lo && c <= hi);
      if (!pend && (dense || ($urandom % 3) != 0)) begin
        case ($urandom % 4)
          0: begin a = $urandom; b = ~a; end
          1: begin a = '1; b = $urandom % 16; end
          2: begin a = $urandom % 256; b = $urandom % 256; end
          default: begin a = $urandom; b = $urandom; end
        endcase
        cin       = 1'($urandom % 2);
        appr_segs = APW'($urandom_range(0, 15));
        pend      = 1;
      end
      in_valid = pend;
      #4;
      if (!in_ready) low++;
      if (in_valid && in_ready) begin
        push(a, b, cin, appr_segs, 0, '0, 1'b0);
        pend = 0;
        idx++;
      end
      c++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (idx < n) begin
      checks++;
      fails++;
      $display("FAIL stream_timeout got=%0d exp=%0d", idx, n);
    end
  endtask

  initial begin
    int tr;
    int low;
    int t;
    checks    = 0;
    fails     = 0;
    cyc       = 0;
    stall_cnt = 0;
    ref_cnt   = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    appr_segs = '0;
    out_ready = 1'b1;
`ifdef AMA_ERR_MON_EN
    err_clr   = 1'b0;
`endif
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef AMA_ERR_MON_EN
    check("rst_err_flag", err_flag, 0);
    check("rst_err_cnt", err_cnt, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    put(32'hFFFF_FFFF, 32'h1, 1'b0, 4'd0, 1, {1'b1, 32'h0}, 1'b0, tr);
    drain();
    put(32'h3, 32'h5, 1'b0, 4'd1, 1, {1'b0, 32'h4}, 1'b1, tr);
    drain();
`ifdef AMA_ERR_MON_EN
    #1 check("err_cnt_one", err_cnt, 1);
`endif
    put(32'h8000_0000, 32'h0, 1'b0, 4'd15, 1, {1'b1, 32'h0}, 1'b1, tr);
    put(32'h8000_0000, 32'h0, 1'b0, 4'd8, 1, {1'b1, 32'h0}, 1'b1, tr);
    for (int i = 0; i < 4; i++) begin
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      x = $urandom;
      y = $urandom;
      put(x, y, 1'b1, 4'd15, 0, '0, 1'b0, tr);
      put(x, y, 1'b1, 4'd8, 0, '0, 1'b0, tr);
    end
    drain();

    stream(10, 1, 6, 9, 0, low);
    check("in_ready_low_cycles", low, 4);
    drain();

    stream(300, 0, -1, -1, 1, low);
    drain();

`ifdef AMA_ERR_MON_EN
    put(32'h3, 32'h5, 1'b0, 4'd1, 1, {1'b0, 32'h4}, 1'b1, tr);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1 check("err_clr_cnt", err_cnt, 0);
    drain();
`endif

    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put($urandom, $urandom, 1'b0, 4'd2, 0, '0, 1'b0, tr);
    end
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    q.delete();
    ref_cnt = '0;
    #1 check("mid_rst_out_valid", out_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    put(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 4'd3, 0, '0, 1'b0, tr);
    check("post_rst_first_accept", tr, 1);
    drain();
    repeat (6) @(negedge clk);
    #1 check("post_rst_idle", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ama_pipe_adder.md
# ama_pipe_adder

Parametrised, pipelined approximate adder built from 4-bit mirror-adder segments. Each segment is either exact or approximation-4 (AMA4), selected at runtime per operation. It generalises the fixed 4-bit ripple block to WIDTH bits, inserts pipeline registers every SEG_PER_STAGE segments, and carries operands through a valid/ready handshake. It sits between operand sourcing and the accumulation datapath in the approximate arithmetic test fabric.

## Interface
- WIDTH, 32: operand/sum width; multiple of 4. NSEG = WIDTH/4.
- SEG_PER_STAGE, 2: 4-bit segments per pipeline stage; must divide NSEG. STAGES = NSEG/SEG_PER_STAGE.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  pipeline accepts beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in to bit 0.
- appr_segs  in  clog2(NSEG+1)  count of low segments using approximate cells; values above NSEG are treated as NSEG.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of the MSB.

## Operation
- Exact cell: s = a^b^c; co = ab | ac | bc.
- Approximate cell (AMA4): co = a; s = b & (~a | c).
- Segment j covers bits [4j+3:4j]. It is approximate iff j < appr_segs, sampled at acceptance and carried with the beat.
- Carries ripple across segments and across stage boundaries. Each stage register holds:
  - valid bit
  - completed sum bits
  - stage carry
  - unconsumed upper operand bits
  - latched appr_segs
- Stage k computes segments [k·SEG_PER_STAGE, (k+1)·SEG_PER_STAGE−1].
- Elastic pipeline: stage k loads when it is empty or stage k+1 loads, or, for the last stage, when out_ready=1.
- in_ready = stage-0 load condition.
- No beat is dropped or duplicated.
- Reset clears all valid bits; sum, cout and out_valid are 0. Data registers need not reset.

## Timing
- Latency: STAGES cycles from acceptance (in_valid&in_ready) to out_valid, with no stall.
- Throughput: 1 beat/cycle while out_ready=1.
- out_valid, sum and cout are registered outputs. They stay stable while out_valid & ~out_ready.
- in_ready is combinational from out_ready and the stage valids. It falls only when all STAGES registers are full and out_ready=0.
- Simultaneous accept and drain on a full pipeline: both happen; occupancy is unchanged.
- rst_n low mid-operation: in-flight beats are discarded immediately. out_valid=0 asynchronously. The first acceptance is possible on the first edge after deassertion.

## Configuration
- AMA_ERR_MON_EN defined adds:
  - an exact shadow adder, carried through the same pipeline;
  - port err_clr (in, 1): synchronous clear;
  - port err_flag (out, 1): high with out_valid when {cout,sum} ≠ the exact result;
  - port err_cnt (out, 16): counts erroneous beats on handshake, saturating at 0xFFFF.
- err_clr has priority over an increment in the same cycle.
- err_flag and err_cnt reset to 0.
- AMA_ERR_MON_EN undefined: these ports and the shadow logic are absent. Datapath behaviour is identical in both builds.

## Test plan
- Exact carry chain (WIDTH=32, SEG_PER_STAGE=2): appr_segs=0, a=0xFFFFFFFF, b=1, cin=0 → 4 cycles later sum=0, cout=1, err_flag=0.
- Approximate low segment: appr_segs=1, a=3, b=5, cin=0 → sum=0x4, cout=0 (exact 0x8), err_flag=1, err_cnt=1.
- Stream and backpressure: 10 back-to-back beats with out_ready held 0 for cycles 6–9.
  - in_ready drops after 4 accepted beats;
  - all 10 results emerge in order, unchanged;
  - sum is stable while stalled.
- Saturation of appr_segs: appr_segs=15 gives the same result as appr_segs=8. a=0x80000000, b=0, cin=0 → sum=0, cout=1.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight → out_valid=0 immediately. No stale result appears after release; a new beat returns after 4 cycles.
- Counter: err_clr pulsed in the same cycle as an erroneous handshake → err_cnt=0.
